// File: rtl/modulo_decodificador_dezena_unidade_rolhas.sv
// Two-digit BCD (tens, units) to binary converter for the cork-count datapath.
// Iterative reverse double-dabble: one shift-and-correct step per clock, start/busy/done handshake.
module modulo_decodificador_dezena_unidade_rolhas #(
  parameter int BIN_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       dezena,
  input  logic [3:0]       unidade,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] valor,
  output logic             erro
);

  localparam int SR_W  = BIN_W + 8;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Handshake: start is sampled only in IDLE; busy is high for the BIN_W
  // SHIFT cycles; done pulses for one cycle when valor/erro are final.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  valor_q, valor_d;
  logic              erro_q, erro_d;

  logic [SR_W-1:0]   sr_step;
  logic [SR_W-1:0]   shifted;
  logic [3:0]        nib_hi, nib_lo;
  logic              digits_ok;

  assign digits_ok = (dezena <= 4'd9) && (unidade <= 4'd9);

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that reached 8 or more back down by 3.
  always_comb begin
    shifted = sr_q >> 1;
    nib_hi  = shifted[SR_W-1 -: 4];
    nib_lo  = shifted[BIN_W+3 -: 4];
    if (nib_hi >= 4'd8) nib_hi = nib_hi - 4'd3;
    if (nib_lo >= 4'd8) nib_lo = nib_lo - 4'd3;
    sr_step = {nib_hi, nib_lo, shifted[BIN_W-1:0]};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valor_d = valor_q;
    erro_d  = erro_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (digits_ok) begin
            sr_d    = {dezena, unidade, {BIN_W{1'b0}}};
            cnt_d   = '0;
            erro_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            erro_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          valor_d = sr_step[BIN_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      valor_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valor_q <= valor_d;
      erro_q  <= erro_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign valor = valor_q;
  assign erro  = erro_q;

endmodule

// File: tb/tb_modulo_decodificador_dezena_unidade_rolhas.sv
// Directed + randomized checks of the BCD-to-binary converter against an arithmetic model
// (value = 10*tens + units, error when a digit exceeds 9).
module tb_modulo_decodificador_dezena_unidade_rolhas;

  localparam int BIN_W = 7;

  logic             clock;
  logic             reset;
  logic             start;
  logic [3:0]       dezena;
  logic [3:0]       unidade;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] valor;
  logic             erro;

  int total;
  int bad;
  int model_valor;
  int model_erro;

  modulo_decodificador_dezena_unidade_rolhas #(.BIN_W(BIN_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .dezena  (dezena),
    .unidade (unidade),
    .busy    (busy),
    .done    (done),
    .valor   (valor),
    .erro    (erro)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
  task automatic run_conv(input int d, input int u, input bit hold_start);
    int cyc;
    int exp_lat;
    int prev_valor;
    bit seen;
    prev_valor = model_valor;
    if (d > 9 || u > 9) begin
      model_erro = 1;
      exp_lat    = 1;
    end else begin
      model_erro  = 0;
      model_valor = 10 * d + u;
      exp_lat     = BIN_W + 1;
    end
    start   = 1'b1;
    dezena  = 4'(d);
    unidade = 4'(u);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        check("busy_in_shift", int'(busy), 1);
        check("valor_stable", int'(valor), prev_valor);
      end
      if (cyc == 1) begin
        if (!hold_start) start = 1'b0;
        dezena  = 4'($urandom_range(15));
        unidade = 4'($urandom_range(15));
      end
    end
    check("latency", cyc, exp_lat);
    check("busy_in_done", int'(busy), 0);
    check("valor", int'(valor), model_valor);
    check("erro", int'(erro), model_erro);
    if (hold_start) begin
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check("hold_no_reaccept_busy", int'(busy), 0);
    end else begin
      start = 1'b0;
      @(negedge clock);
    end
    check("done_single_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int order[100];
    int tmp;
    int j;
    total       = 0;
    bad         = 0;
    model_valor = 0;
    model_erro  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    dezena  = 4'd0;
    unidade = 4'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valor", int'(valor), 0);
    check("rst_erro", int'(erro), 0);

    run_conv(0, 0, 1'b0);
    run_conv(9, 9, 1'b0);
    run_conv(1, 0, 1'b0);

    for (int i = 0; i < 100; i++) order[i] = i;
    for (int i = 99; i > 0; i--) begin
      j        = $urandom_range(i);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 100; i++) run_conv(order[i] / 10, order[i] % 10, 1'b0);

    run_conv(4, 2, 1'b0);
    run_conv(10, 3, 1'b0);
    run_conv($urandom_range(9), $urandom_range(9), 1'b0);

    run_conv($urandom_range(9), $urandom_range(9), 1'b1);
    run_conv(12, $urandom_range(15), 1'b1);

    for (int i = 0; i < 30; i++) run_conv($urandom_range(15), $urandom_range(15), 1'b0);

    // Reset landing on the 4th SHIFT cycle of a conversion of 57.
    run_conv(3, 1, 1'b0);
    start   = 1'b1;
    dezena  = 4'd5;
    unidade = 4'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset       = 1'b0;
    model_valor = 0;
    model_erro  = 0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_valor", int'(valor), 0);
    check("midrst_erro", int'(erro), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("midrst_no_done", int'(done), 0);
    end
    run_conv(5, 7, 1'b0);

    // Reset and start together: reset wins.
    reset   = 1'b1;
    start   = 1'b1;
    dezena  = 4'd2;
    unidade = 4'd2;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    model_valor = 0;
    model_erro  = 0;
    check("rst_start_busy", int'(busy), 0);
    check("rst_start_done", int'(done), 0);
    check("rst_start_valor", int'(valor), 0);
    @(negedge clock);
    check("rst_start_idle", int'(busy), 0);
    run_conv(6, 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
